// File: rtl/xlb_apfifo_in_bridge.sv
// -----------------------------------------------------------------------------
// xlb_apfifo_in_bridge
//
// Upstream feeder for the HLS stream core. Turns a standard-read host-to-PL
// FIFO (read data valid one cycle after fifo_rd_en) into an ap_fifo style
// input (hls_dout / hls_empty_n / hls_read) through a 2-entry prefetch buffer.
// Sustains one word per cycle. Deasserting port_open flushes the bridge on
// the next clock edge.
//
// Ports:
//   bus_clk      in   single clock
//   bus_rst_n    in   asynchronous active-low reset
//   port_open    in   host write file open; low = synchronous flush
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  FIFO read strobe (combinational)
//   hls_dout     out  head word presented to the HLS core (registered)
//   hls_empty_n  out  head word valid (registered)
//   hls_read     in   HLS consumes the head word this cycle
//   word_count   out  words accepted by HLS since last flush/reset
//   overflow_err out  sticky: a returned word arrived with the buffer full
// -----------------------------------------------------------------------------
module xlb_apfifo_in_bridge #(
    parameter int DW   = 32,
    parameter int CNTW = 32
) (
    input  logic            bus_clk,
    input  logic            bus_rst_n,
    input  logic            port_open,
    input  logic [DW-1:0]   fifo_dout,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    output logic [DW-1:0]   hls_dout,
    output logic            hls_empty_n,
    input  logic            hls_read,
    output logic [CNTW-1:0] word_count,
    output logic            overflow_err
);

    logic [1:0]      cnt_r;
    logic            inflight_r;
    logic [DW-1:0]   head_r;
    logic [DW-1:0]   tail_r;
    logic            empty_n_r;
    logic [CNTW-1:0] word_count_r;
    logic            overflow_r;

    logic            pop_s;
    logic [1:0]      occ_s;
    logic [1:0]      cnt_nxt_s;
    logic [DW-1:0]   head_nxt_s;
    logic [DW-1:0]   tail_nxt_s;
    logic            ovf_set_s;

    // A read while the buffer is empty is ignored entirely.
    assign pop_s = hls_read & empty_n_r;

    // Occupancy after this cycle if nothing new is requested. cnt+inflight is
    // at most 3 and pop only happens when cnt>=1, so 2 bits never wrap.
    assign occ_s = cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};

    // FIFO read strobe: only request when the returning word is guaranteed a
    // slot. Gated by reset so the strobe drops without waiting for a clock.
    always_comb begin
        if (bus_rst_n && port_open && !fifo_empty && (occ_s < 2'd2)) begin
            fifo_rd_en = 1'b1;
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    // Next buffer state from the (push = inflight, pop) combination.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        ovf_set_s  = 1'b0;
        case (cnt_r)
            2'd0: begin
                if (inflight_r) begin
                    head_nxt_s = fifo_dout;
                    cnt_nxt_s  = 2'd1;
                end else begin
                    cnt_nxt_s  = 2'd0;
                end
            end
            2'd1: begin
                case ({inflight_r, pop_s})
                    2'b11:   head_nxt_s = fifo_dout;
                    2'b10: begin
                        tail_nxt_s = fifo_dout;
                        cnt_nxt_s  = 2'd2;
                    end
                    2'b01:   cnt_nxt_s = 2'd0;
                    default: cnt_nxt_s = 2'd1;
                endcase
            end
            2'd2: begin
                case ({inflight_r, pop_s})
                    2'b11: begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = fifo_dout;
                    end
                    // Word returned with no room: dropped and flagged.
                    2'b10:   ovf_set_s = 1'b1;
                    2'b01: begin
                        head_nxt_s = tail_r;
                        cnt_nxt_s  = 2'd1;
                    end
                    default: cnt_nxt_s = 2'd2;
                endcase
            end
            default: cnt_nxt_s = 2'd0;
        endcase
    end

    // State registers; port_open low clears the datapath but keeps overflow.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            cnt_r        <= 2'd0;
            inflight_r   <= 1'b0;
            head_r       <= {DW{1'b0}};
            tail_r       <= {DW{1'b0}};
            empty_n_r    <= 1'b0;
            word_count_r <= {CNTW{1'b0}};
            overflow_r   <= 1'b0;
        end else if (!port_open) begin
            cnt_r        <= 2'd0;
            inflight_r   <= 1'b0;
            empty_n_r    <= 1'b0;
            word_count_r <= {CNTW{1'b0}};
        end else begin
            cnt_r        <= cnt_nxt_s;
            inflight_r   <= fifo_rd_en;
            head_r       <= head_nxt_s;
            tail_r       <= tail_nxt_s;
            empty_n_r    <= (cnt_nxt_s != 2'd0);
            word_count_r <= word_count_r + {{(CNTW-1){1'b0}}, pop_s};
            overflow_r   <= overflow_r | ovf_set_s;
        end
    end

    assign hls_dout     = head_r;
    assign hls_empty_n  = empty_n_r;
    assign word_count   = word_count_r;
    assign overflow_err = overflow_r;

endmodule
